wall_scroller: RTL



---
 rtl/wall_scroller.sv | 112 +++++++++++
 1 files changed

// File: rtl/wall_scroller.sv
// wall_scroller: spawns one wall at a time, scrolls it left on frame ticks, detects bird passes, and keeps a score.
// Ports: clk, reset (sync, active-high), enable (low = pause), frame_tick (one pulse per frame),
//        rand_height (random height source), rand_req (pulse while rand_height is sampled),
//        wall_x/prev_x (current and previous left edge), gap_top/gap_bot (gap rows),
//        moved/passed (one-cycle pulses), score (saturating pass count), active (high in RUN).
// Optional feature: define WALL_SPEEDUP_EN to raise the scroll speed by 1 every 8 passes, capped at 4.
module wall_scroller #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int WALL_W   = 8,
    parameter int GAP_H    = 40,
    parameter int MIN_TOP  = 8,
    parameter int BIRD_X   = 40,
    parameter int SPEED    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [7:0] rand_height,
    output logic       rand_req,
    output logic [7:0] wall_x,
    output logic [7:0] prev_x,
    output logic [6:0] gap_top,
    output logic [6:0] gap_bot,
    output logic       moved,
    output logic       passed,
    output logic [7:0] score,
    output logic       active
);
    localparam logic [6:0] RANGE = 7'(SCREEN_H - GAP_H - 2 * MIN_TOP);
    localparam logic [7:0] START = 8'(SCREEN_W - WALL_W);
    localparam logic [8:0] WW    = 9'(WALL_W);
    localparam logic [8:0] BX    = 9'(BIRD_X);
    typedef enum logic [1:0] {IDLE, SPAWN, RUN} state_t;
    state_t     state;
    logic [8:0] speed;
`ifdef WALL_SPEEDUP_EN
    logic [2:0] spd;
    assign speed = {6'd0, spd};
`else
    assign speed = 9'(SPEED);
`endif
    logic [6:0] raw, fold, off;
    logic [8:0] wx, nx;
    logic       pass;
    always_comb begin
        raw  = rand_height[6:0];
        // Fold once into range, then clamp anything still out of range.
        fold = (raw > RANGE) ? raw - (RANGE + 7'd1) : raw;
        off  = (fold > RANGE) ? RANGE : fold;
        wx   = {1'b0, wall_x};
        nx   = wx - speed;
        // Trailing edge is right of the bird before the move and at/left of it after.
        pass = (wx + WW > BX) && (nx + WW <= BX);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wall_x   <= START;
            prev_x   <= START;
            gap_top  <= 7'(MIN_TOP);
            gap_bot  <= 7'(MIN_TOP + GAP_H - 1);
            score    <= 8'd0;
            rand_req <= 1'b0;
            moved    <= 1'b0;
            passed   <= 1'b0;
            active   <= 1'b0;
`ifdef WALL_SPEEDUP_EN
            spd      <= 3'(SPEED);
`endif
        end else begin
            rand_req <= 1'b0;
            moved    <= 1'b0;
            passed   <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    state    <= SPAWN;
                    rand_req <= 1'b1;
                end
                // Completes unconditionally; any frame_tick here is dropped.
                SPAWN: begin
                    state   <= RUN;
                    active  <= 1'b1;
                    wall_x  <= START;
                    prev_x  <= START;
                    gap_top <= 7'(MIN_TOP) + off;
                    gap_bot <= 7'(MIN_TOP) + off + 7'(GAP_H - 1);
                end
                RUN: if (enable && frame_tick) begin
                    if (wx < speed) begin
                        state    <= SPAWN;
                        rand_req <= 1'b1;
                        active   <= 1'b0;
                    end else begin
                        prev_x <= wall_x;
                        wall_x <= nx[7:0];
                        moved  <= 1'b1;
                        if (pass) begin
                            passed <= 1'b1;
                            if (score != 8'd255) score <= score + 8'd1;
`ifdef WALL_SPEEDUP_EN
                            if (score != 8'd255 && score[2:0] == 3'd7 && spd < 3'd4) spd <= spd + 3'd1;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
